hand_centroid_ctrl: RTL and testbench
=====================================

Name: hand_centroid_ctrl

Overview:
- Frame-level controller for the skin-mask centroid datapath.
- Consumes the per-pixel mask decision (R−G window hit) alongside the display counters, and accumulates hit coordinates over the active area.
- At frame end it snapshots the sums and runs a sequential divider to produce the X/Y centroid.
- Publishes the centroid to the hex-display and game logic at a rate-limited interval.

Parameters:
H_ACTIVE, 320, active columns; hcnt >= H_ACTIVE is ignored
V_ACTIVE, 240, active rows; vcnt >= V_ACTIVE is ignored
SUM_W, 27, accumulator and dividend width (covers 76800 × 1023)
CNT_W, 17, hit-counter and divisor width
MIN_PIXELS, 64, minimum hit count for a valid object
UPDATE_CYCLES, 5000000, clocks between publications

Ports:
clock  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
frame_end  in  1  single-cycle pulse from sync generator after last active pixel
pix_valid  in  1  ActiveArea qualifier
hcnt  in  10  current column
vcnt  in  10  current row
mask_hit  in  1  pixel passes skin threshold
xpos  out  10  published centroid column
ypos  out  10  published centroid row
pos_valid  out  1  one-cycle strobe when xpos/ypos are updated
object_found  out  1  latched with each publication; 0 = last frame below MIN_PIXELS
busy  out  1  high while the divider is running
overrun  out  1  one-cycle pulse when frame_end arrives while busy

Behaviour:
- Reset (async, reset_n=0): state=ACCUM; all accumulators, snapshot, latest and publish counters cleared; xpos=0, ypos=0, pos_valid=0, object_found=0, busy=0, overrun=0, latest_valid=0.
- Accumulation runs continuously, independent of the FSM.
  - Qualifying pixel: pix_valid && mask_hit && hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - On a qualifying pixel: sum_x += hcnt, sum_y += vcnt, cnt += 1.
  - Each accumulator saturates at its all-ones value.
- On frame_end, accumulators clear to 0 on the same edge.
  - A pixel qualifying in the frame_end cycle is included in the frame being closed.
- FSM states: ACCUM, DIV_X, DIV_Y, DONE.
  - ACCUM, frame_end:
    - Snapshot sum_x, sum_y and cnt (including the same-cycle pixel).
    - If snapshot cnt < MIN_PIXELS: go to DONE with no_obj=1, skipping division.
    - Otherwise: go to DIV_X with no_obj=0.
  - DIV_X: restoring division sum_x/cnt, one quotient bit per cycle MSB first. Exactly SUM_W cycles, then go to DIV_Y.
  - DIV_Y: same operation on sum_y/cnt, SUM_W cycles, then go to DONE.
  - DONE (1 cycle):
    - If no_obj=0: latest_x/latest_y take quotient[9:0] (the quotient never exceeds H_ACTIVE−1 / V_ACTIVE−1).
    - Always: latest_found takes !no_obj; latest_valid is set to 1.
    - Return to ACCUM.
  - Latency from frame_end to the DONE edge: 1 + 2×SUM_W cycles (55 at defaults); 1 cycle on the no-object path.
  - busy=1 in DIV_X, DIV_Y and DONE.
- Overrun:
  - frame_end while state≠ACCUM: that frame's snapshot is discarded and the divider is not disturbed.
  - Accumulators still clear; overrun pulses for 1 cycle.
- Divide by zero cannot occur: the cnt=0 case takes the no-object path, given MIN_PIXELS ≥ 1; MIN_PIXELS must be ≥ 1.
- Publication:
  - pub_cnt is free-running from 0 to UPDATE_CYCLES−1 and wraps to 0.
  - At terminal count, if latest_valid=1:
    - xpos<=latest_x, ypos<=latest_y, object_found<=latest_found.
    - pos_valid=1 for that one cycle.
  - If latest_valid=0: no update and no strobe.
  - No-object frame: xpos/ypos hold their previous values and only object_found drops to 0.
  - DONE coinciding with terminal count: publish the pre-edge latest values; the new result goes out at the next terminal count.
- reset_n asserted mid-division aborts immediately to the reset state. The first frame_end after release starts a fresh frame; the partial frame's accumulation is lost.

Test Plan (H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=2, UPDATE_CYCLES=200, SUM_W=27):
- Hits at (2,1), (4,1), (6,3), then frame_end → busy for 55 cycles. At the next terminal count: xpos=4, ypos=1 (5/3 truncated), object_found=1, pos_valid exactly 1 cycle.
- Single hit at (5,2), then frame_end → no_obj path, DONE after 1 cycle. Next publication: xpos/ypos unchanged, object_found=0.
- Hits with hcnt=8 or vcnt=4, or pix_valid=0 → not counted. An all-out-of-area frame gives object_found=0.
- Second frame_end 10 cycles after the first → overrun pulses once; the first result is published correctly; the second frame's pixels are not in the next snapshot.
- Hit at (7,3) in the same cycle as frame_end, plus one earlier hit at (1,3) → xpos=4, ypos=3.
- reset_n low during DIV_Y → all outputs 0 asynchronously. After release, pos_valid stays low until a full frame completes and a terminal count occurs.

Source files
------------

// File: rtl/hand_centroid_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : hand_centroid_ctrl_if
// Brief  : Pixel-stream inputs and centroid results of the hand centroid controller.
// Rev    : 1.0  initial release
// ============================================================================
interface hand_centroid_ctrl_if;
  logic       frame_end;
  logic       pix_valid;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       mask_hit;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       pos_valid;
  logic       object_found;
  logic       busy;
  logic       overrun;

  modport master (
    output frame_end, pix_valid, hcnt, vcnt, mask_hit,
    input  xpos, ypos, pos_valid, object_found, busy, overrun
  );

  modport slave (
    input  frame_end, pix_valid, hcnt, vcnt, mask_hit,
    output xpos, ypos, pos_valid, object_found, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/hand_centroid_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hand_centroid_ctrl
// Brief  : Accumulates skin-mask hit coordinates per frame, divides out the
//          centroid and publishes it at a fixed interval.
// Rev    : 1.0  initial release
// ============================================================================
module hand_centroid_ctrl #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int SUM_W         = 27,
  parameter int CNT_W         = 17,
  parameter int MIN_PIXELS    = 64,
  parameter int UPDATE_CYCLES = 5000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  hand_centroid_ctrl_if.slave   bus
);

  localparam int c_bit_w = $clog2(SUM_W);
  localparam int c_pub_w = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(SUM_W - 1);
  localparam logic [c_pub_w-1:0] c_pub_last   = c_pub_w'(UPDATE_CYCLES - 1);
  localparam logic [9:0]         c_h_active   = 10'(H_ACTIVE);
  localparam logic [9:0]         c_v_active   = 10'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   c_min_pixels = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DIV_X = 2'd1,
    S_DIV_Y = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [SUM_W-1:0]   r_sum_x, r_sum_y, r_snap_y, r_quot;
  logic [CNT_W-1:0]   r_cnt, r_divisor, r_rem;
  logic [c_bit_w-1:0] r_bit;
  logic               r_no_obj, r_busy, r_overrun;
  logic [9:0]         r_res_x, r_latest_x, r_latest_y;
  logic               r_latest_found, r_latest_valid;
  logic [c_pub_w-1:0] r_pub_cnt;
  logic [9:0]         r_xpos, r_ypos;
  logic               r_pos_valid, r_object_found;

  // Next-cycle accumulator values, saturating at all-ones
  logic               w_qual;
  logic [SUM_W:0]     w_sx_add, w_sy_add;
  logic [CNT_W:0]     w_cnt_add;
  logic [SUM_W-1:0]   w_sx_nxt, w_sy_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_qual    = bus.pix_valid && bus.mask_hit &&
                     (bus.hcnt < c_h_active) && (bus.vcnt < c_v_active);
  assign w_sx_add  = {1'b0, r_sum_x} + (SUM_W+1)'(bus.hcnt);
  assign w_sy_add  = {1'b0, r_sum_y} + (SUM_W+1)'(bus.vcnt);
  assign w_cnt_add = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_sx_nxt  = !w_qual ? r_sum_x : (w_sx_add[SUM_W]  ? '1 : w_sx_add[SUM_W-1:0]);
  assign w_sy_nxt  = !w_qual ? r_sum_y : (w_sy_add[SUM_W]  ? '1 : w_sy_add[SUM_W-1:0]);
  assign w_cnt_nxt = !w_qual ? r_cnt   : (w_cnt_add[CNT_W] ? '1 : w_cnt_add[CNT_W-1:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (bus.frame_end) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else begin
      r_sum_x <= w_sx_nxt;
      r_sum_y <= w_sy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Restoring divider step: dividend bits shift out of r_quot as quotient bits shift in
  logic [CNT_W:0]   w_rem_sh;
  logic [CNT_W-1:0] w_rem_sub, w_rem_nxt;
  logic             w_ge;
  logic [SUM_W-1:0] w_quot_nxt;

  assign w_rem_sh   = {r_rem, r_quot[SUM_W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_sub  = w_rem_sh[CNT_W-1:0] - r_divisor;
  assign w_rem_nxt  = w_ge ? w_rem_sub : w_rem_sh[CNT_W-1:0];
  assign w_quot_nxt = {r_quot[SUM_W-2:0], w_ge};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_ACCUM;
      r_snap_y       <= '0;
      r_quot         <= '0;
      r_divisor      <= '0;
      r_rem          <= '0;
      r_bit          <= '0;
      r_no_obj       <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_res_x        <= '0;
      r_latest_x     <= '0;
      r_latest_y     <= '0;
      r_latest_found <= 1'b0;
      r_latest_valid <= 1'b0;
    end else begin
      r_overrun <= bus.frame_end && (r_state != S_ACCUM);
      case (r_state)
        S_ACCUM: begin
          if (bus.frame_end) begin
            r_quot    <= w_sx_nxt;
            r_snap_y  <= w_sy_nxt;
            r_divisor <= w_cnt_nxt;
            r_rem     <= '0;
            r_bit     <= '0;
            r_busy    <= 1'b1;
            if (w_cnt_nxt < c_min_pixels) begin
              r_no_obj <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_no_obj <= 1'b0;
              r_state  <= S_DIV_X;
            end
          end
        end
        S_DIV_X: begin
          r_quot <= w_quot_nxt;
          r_rem  <= w_rem_nxt;
          r_bit  <= r_bit + 1'b1;
          if (r_bit == c_bit_last) begin
            r_res_x <= w_quot_nxt[9:0];
            r_quot  <= r_snap_y;
            r_rem   <= '0;
            r_bit   <= '0;
            r_state <= S_DIV_Y;
          end
        end
        S_DIV_Y: begin
          r_quot <= w_quot_nxt;
          r_rem  <= w_rem_nxt;
          r_bit  <= r_bit + 1'b1;
          if (r_bit == c_bit_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!r_no_obj) begin
            r_latest_x <= r_res_x;
            r_latest_y <= r_quot[9:0];
          end
          r_latest_found <= !r_no_obj;
          r_latest_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= S_ACCUM;
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pub_cnt      <= '0;
      r_xpos         <= '0;
      r_ypos         <= '0;
      r_object_found <= 1'b0;
      r_pos_valid    <= 1'b0;
    end else begin
      r_pos_valid <= 1'b0;
      if (r_pub_cnt == c_pub_last) begin
        r_pub_cnt <= '0;
        if (r_latest_valid) begin
          r_xpos         <= r_latest_x;
          r_ypos         <= r_latest_y;
          r_object_found <= r_latest_found;
          r_pos_valid    <= 1'b1;
        end
      end else begin
        r_pub_cnt <= r_pub_cnt + 1'b1;
      end
    end
  end

  assign bus.xpos         = r_xpos;
  assign bus.ypos         = r_ypos;
  assign bus.pos_valid    = r_pos_valid;
  assign bus.object_found = r_object_found;
  assign bus.busy         = r_busy;
  assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hand_centroid_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hand_centroid_ctrl
// Brief  : Directed and random frames against a frame-level centroid model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hand_centroid_ctrl;

  localparam int H_ACT   = 8;
  localparam int V_ACT   = 4;
  localparam int MIN_PIX = 2;
  localparam int UPD     = 200;
  localparam int SUMW    = 27;

  logic clock;
  logic reset_n;
  hand_centroid_ctrl_if bus();

  hand_centroid_ctrl #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .SUM_W(SUMW), .CNT_W(17),
    .MIN_PIXELS(MIN_PIX), .UPDATE_CYCLES(UPD)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int x; int y; bit f; } pub_t;
  pub_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int ovr_seen = 0;
  int pv_seen = 0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Frame-level reference: sums per frame, result ready 1+2*SUM_W edges after frame_end
  int cyc = 0;
  int m_sx = 0, m_sy = 0, m_cnt = 0;
  int done_edge = -1;
  int pend_x = 0, pend_y = 0;
  bit pend_f = 0;
  int lat_x = 0, lat_y = 0;
  bit lat_f = 0, lat_v = 0;
  bit m_busy_exp = 0, m_ovr_exp = 0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      cyc = 0; m_sx = 0; m_sy = 0; m_cnt = 0; done_edge = -1;
      lat_x = 0; lat_y = 0; lat_f = 0; lat_v = 0;
      m_busy_exp = 0; m_ovr_exp = 0;
      exp_q.delete();
    end else begin
      pub_t p;
      if (bus.pix_valid && bus.mask_hit && bus.hcnt < H_ACT && bus.vcnt < V_ACT) begin
        m_sx += bus.hcnt; m_sy += bus.vcnt; m_cnt++;
      end
      if (cyc % UPD == UPD - 1 && lat_v) begin
        p.x = lat_x; p.y = lat_y; p.f = lat_f;
        exp_q.push_back(p);
      end
      if (cyc == done_edge) begin
        lat_x = pend_x; lat_y = pend_y; lat_f = pend_f; lat_v = 1;
      end
      m_ovr_exp = 0;
      if (bus.frame_end) begin
        if (cyc <= done_edge) m_ovr_exp = 1;
        else if (m_cnt < MIN_PIX) begin
          done_edge = cyc + 1; pend_x = lat_x; pend_y = lat_y; pend_f = 0;
        end else begin
          done_edge = cyc + 1 + 2 * SUMW;
          pend_x = m_sx / m_cnt; pend_y = m_sy / m_cnt; pend_f = 1;
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
      end
      m_busy_exp = (cyc < done_edge);
      cyc++;
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      check("busy", bus.busy, m_busy_exp);
      check("overrun", bus.overrun, m_ovr_exp);
      if (bus.overrun) ovr_seen++;
      if (bus.pos_valid) begin
        pv_seen++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_pos_valid: got 1 expected 0");
        end else begin
          pub_t p;
          p = exp_q.pop_front();
          check("xpos", bus.xpos, p.x);
          check("ypos", bus.ypos, p.y);
          check("object_found", bus.object_found, p.f);
        end
      end
    end
  end

  task automatic drive(input int h, input int v, input bit pv, input bit mh, input bit fe);
    @(negedge clock);
    bus.hcnt = 10'(h); bus.vcnt = 10'(v);
    bus.pix_valid = pv; bus.mask_hit = mh; bus.frame_end = fe;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_pub(input string tag, input int x, input int y, input int f);
    check({tag, "_xpos"}, bus.xpos, x);
    check({tag, "_ypos"}, bus.ypos, y);
    check({tag, "_found"}, bus.object_found, f);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_xpos"}, bus.xpos, 0);
    check({tag, "_ypos"}, bus.ypos, 0);
    check({tag, "_pos_valid"}, bus.pos_valid, 0);
    check({tag, "_found"}, bus.object_found, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    bus.hcnt = '0; bus.vcnt = '0; bus.pix_valid = 1'b0; bus.mask_hit = 1'b0; bus.frame_end = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Three hits: centroid (12/3, 5/3) = (4, 1)
    drive(2, 1, 1, 1, 0); drive(4, 1, 1, 1, 0); drive(6, 3, 1, 1, 0);
    drive(0, 0, 0, 0, 1);
    idle(260);
    check_pub("three_hits", 4, 1, 1);

    // Single hit below MIN_PIXELS keeps the old position
    drive(5, 2, 1, 1, 0); drive(0, 0, 0, 0, 1);
    idle(260);
    check_pub("single_hit", 4, 1, 0);

    // Nothing in the active area qualifies
    drive(8, 1, 1, 1, 0); drive(3, 4, 1, 1, 0); drive(2, 2, 0, 1, 0); drive(9, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1);
    idle(260);
    check_pub("out_of_area", 4, 1, 0);

    // Second frame_end 10 cycles into the division
    base = ovr_seen;
    drive(1, 1, 1, 1, 0); drive(3, 1, 1, 1, 1);
    repeat (9) drive(7, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1);
    idle(260);
    check("overrun_pulses", ovr_seen - base, 1);
    check_pub("overrun_first", 2, 1, 1);
    drive(0, 0, 1, 1, 0); drive(2, 2, 1, 1, 0); drive(0, 0, 0, 0, 1);
    idle(260);
    check_pub("after_overrun", 1, 1, 1);

    // Same-cycle pixel belongs to the frame being closed
    drive(1, 3, 1, 1, 0); drive(7, 3, 1, 1, 1);
    idle(260);
    check_pub("same_cycle", 4, 3, 1);

    // Reset in the middle of the Y division
    drive(2, 1, 1, 1, 0); drive(4, 1, 1, 1, 0); drive(0, 0, 0, 0, 1);
    idle(40);
    check("busy_before_reset", bus.busy, 1);
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    base = pv_seen;
    idle(250);
    check("no_pub_after_reset", pv_seen - base, 0);
    drive(6, 0, 1, 1, 0); drive(2, 2, 1, 1, 0); drive(0, 0, 0, 0, 1);
    idle(260);
    check_pub("after_reset", 4, 1, 1);

    // Random frames with random density, blanking pixels and gaps
    for (int f = 0; f < 40; f++) begin
      int dens;
      int gap;
      dens = $urandom_range(0, 40);
      for (int v = 0; v <= V_ACT; v++) begin
        for (int h = 0; h < H_ACT + 2; h++) begin
          bit pv;
          pv = (h < H_ACT && v < V_ACT) ? 1'b1 : ($urandom % 4 == 0);
          drive(h, v, pv, ($urandom % 100) < dens, 0);
        end
      end
      drive($urandom_range(0, H_ACT + 1), $urandom_range(0, V_ACT),
            $urandom % 2, $urandom % 2, 1);
      gap = ($urandom % 4 == 0) ? $urandom_range(2, 40) : $urandom_range(60, 250);
      idle(gap);
    end
    idle(460);
    check("pending_publications", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
